// File: rtl/mem_port_seq_if.sv
// mem_port_seq_if: fetch/data request ports plus the byte-RAM bus of mem_port_seq.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

interface mem_port_seq_if;
  logic        p0_req;
  logic [31:0] p0_addr;
  logic        p0_ack;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [1:0]  p1_size;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_ack;
  logic [31:0] p1_rdata;

  logic [31:0] mem_ra1;
  logic [31:0] mem_ra2;
  logic [31:0] mem_wa3;
  logic [31:0] mem_wd3;
  logic        mem_we;
  logic [31:0] mem_rd1;
  logic [31:0] mem_rd2;

  modport slave (
    input  p0_req, p0_addr,
    output p0_ack, p0_rdata,
    input  p1_req, p1_we, p1_size, p1_addr, p1_wdata,
    output p1_ack, p1_rdata,
    output mem_ra1, mem_ra2, mem_wa3, mem_wd3, mem_we,
    input  mem_rd1, mem_rd2
  );

  modport master (
    output p0_req, p0_addr,
    input  p0_ack, p0_rdata,
    output p1_req, p1_we, p1_size, p1_addr, p1_wdata,
    input  p1_ack, p1_rdata,
    input  mem_ra1, mem_ra2, mem_wa3, mem_wd3, mem_we,
    output mem_rd1, mem_rd2
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_seq.sv
// ---------------------------------------------------------------------------
// mem_port_seq: two-port (fetch / load-store) sequencer onto a byte-wide RAM.
// Optional macro MEM_PORT_SEQ_RR_EN: round-robin arbitration (else port 1 wins).
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mem_port_seq #(
  parameter int ADDR_BITS = 9
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mem_port_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_WR    = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_owner;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [1:0]            r_size;
  logic [31:0]           r_wdata;
  logic [1:0]            r_cnt;
  logic [7:0]            r_b0;
  logic [7:0]            r_b1;
  logic [31:0]           r_ra1;
  logic [31:0]           r_ra2;
  logic [31:0]           r_wa3;
  logic [31:0]           r_wd3;
  logic                  r_mem_we;
  logic                  r_p0_ack;
  logic                  r_p1_ack;
  logic [31:0]           r_p0_rdata;
  logic [31:0]           r_p1_rdata;

  logic                  w_any;
  logic                  w_grant1;
  logic [ADDR_BITS-1:0]  w_g_addr;
  logic [1:0]            w_g_size;
  logic                  w_g_we;
  logic [1:0]            w_last_k;
  logic [1:0]            w_next_k;
  logic [31:0]           w_lo_data;
  logic [31:0]           w_word;

`ifdef MEM_PORT_SEQ_RR_EN
  // r_prio = 1 means port 1 wins the next contended grant
  logic                  r_prio;
  assign w_grant1 = bus.p1_req & (~bus.p0_req | r_prio);
`else
  assign w_grant1 = bus.p1_req;
`endif

  assign w_any    = bus.p0_req | bus.p1_req;
  assign w_g_addr = w_grant1 ? bus.p1_addr[ADDR_BITS-1:0] : bus.p0_addr[ADDR_BITS-1:0];
  assign w_g_size = w_grant1 ? bus.p1_size : 2'b10;
  assign w_g_we   = w_grant1 & bus.p1_we;

  assign w_last_k  = (r_size == 2'b00) ? 2'd0 : (r_size == 2'b01) ? 2'd1 : 2'd3;
  assign w_next_k  = r_cnt + 2'd1;
  assign w_lo_data = r_size[0] ? {16'd0, bus.mem_rd2[7:0], bus.mem_rd1[7:0]}
                               : {24'd0, bus.mem_rd1[7:0]};
  assign w_word    = {bus.mem_rd2[7:0], bus.mem_rd1[7:0], r_b1, r_b0};

  logic w_unused_bits;
  assign w_unused_bits = ^{bus.p0_addr[31:ADDR_BITS], bus.p1_addr[31:ADDR_BITS],
                           bus.mem_rd1[31:8], bus.mem_rd2[31:8]};

  function automatic logic [31:0] f_addr(input logic [ADDR_BITS-1:0] base,
                                         input logic [1:0] k);
    logic [ADDR_BITS-1:0] s;
    s = base + ADDR_BITS'(k);
    return 32'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_addr     <= '0;
      r_size     <= 2'b00;
      r_wdata    <= 32'd0;
      r_cnt      <= 2'd0;
      r_b0       <= 8'd0;
      r_b1       <= 8'd0;
      r_ra1      <= 32'd0;
      r_ra2      <= 32'd0;
      r_wa3      <= 32'd0;
      r_wd3      <= 32'd0;
      r_mem_we   <= 1'b0;
      r_p0_ack   <= 1'b0;
      r_p1_ack   <= 1'b0;
      r_p0_rdata <= 32'd0;
      r_p1_rdata <= 32'd0;
`ifdef MEM_PORT_SEQ_RR_EN
      r_prio     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_grant1;
            r_addr  <= w_g_addr;
            r_size  <= w_g_size;
            r_wdata <= bus.p1_wdata;
            r_cnt   <= 2'd0;
`ifdef MEM_PORT_SEQ_RR_EN
            r_prio  <= ~w_grant1;
`endif
            if (w_g_we) begin
              r_state  <= S_WR;
              r_mem_we <= 1'b1;
              r_wa3    <= f_addr(w_g_addr, 2'd0);
              r_wd3    <= {24'd0, bus.p1_wdata[7:0]};
            end else begin
              r_state <= S_RD_LO;
              r_ra1   <= f_addr(w_g_addr, 2'd0);
              r_ra2   <= f_addr(w_g_addr, 2'd1);
            end
          end
        end
        S_RD_LO: begin
          r_b0 <= bus.mem_rd1[7:0];
          r_b1 <= bus.mem_rd2[7:0];
          if (r_size[1]) begin
            r_state <= S_RD_HI;
            r_ra1   <= f_addr(r_addr, 2'd2);
            r_ra2   <= f_addr(r_addr, 2'd3);
          end else begin
            r_state <= S_ACK;
            r_ra1   <= 32'd0;
            r_ra2   <= 32'd0;
            if (r_owner) begin
              r_p1_rdata <= w_lo_data;
              r_p1_ack   <= 1'b1;
            end else begin
              r_p0_rdata <= w_lo_data;
              r_p0_ack   <= 1'b1;
            end
          end
        end
        S_RD_HI: begin
          r_state <= S_ACK;
          r_ra1   <= 32'd0;
          r_ra2   <= 32'd0;
          if (r_owner) begin
            r_p1_rdata <= w_word;
            r_p1_ack   <= 1'b1;
          end else begin
            r_p0_rdata <= w_word;
            r_p0_ack   <= 1'b1;
          end
        end
        S_WR: begin
          // only port 1 can store, so the ack always goes there
          if (r_cnt == w_last_k) begin
            r_state  <= S_ACK;
            r_mem_we <= 1'b0;
            r_wa3    <= 32'd0;
            r_wd3    <= 32'd0;
            r_p1_ack <= 1'b1;
          end else begin
            r_cnt <= w_next_k;
            r_wa3 <= f_addr(r_addr, w_next_k);
            r_wd3 <= {24'd0, r_wdata[{w_next_k, 3'b000} +: 8]};
          end
        end
        S_ACK: begin
          r_state  <= S_IDLE;
          r_p0_ack <= 1'b0;
          r_p1_ack <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset masks strobes immediately so an aborted store writes nothing more
  assign bus.mem_we   = r_mem_we & ~reset;
  assign bus.mem_ra1  = reset ? 32'd0 : r_ra1;
  assign bus.mem_ra2  = reset ? 32'd0 : r_ra2;
  assign bus.mem_wa3  = reset ? 32'd0 : r_wa3;
  assign bus.mem_wd3  = reset ? 32'd0 : r_wd3;
  assign bus.p0_ack   = r_p0_ack & ~reset;
  assign bus.p1_ack   = r_p1_ack & ~reset;
  assign bus.p0_rdata = r_p0_rdata;
  assign bus.p1_rdata = r_p1_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_seq.sv
// tb_mem_port_seq: directed self-checking bench for mem_port_seq with a byte-RAM model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_seq_if bus();

  mem_port_seq #(.ADDR_BITS(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0]  ram [512];
  logic        ram_init;
  logic [31:0] wlog_a [64];
  logic [31:0] wlog_d [64];
  int          wn;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign bus.mem_rd1 = {24'd0, ram[bus.mem_ra1[8:0]]};
  assign bus.mem_rd2 = {24'd0, ram[bus.mem_ra2[8:0]]};

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 512; i++) ram[i] <= 8'h00;
      ram[0]   <= 8'h11;
      ram[1]   <= 8'h22;
      ram[2]   <= 8'h33;
      ram[3]   <= 8'h44;
      ram[511] <= 8'h5A;
      wn       <= 0;
    end else if (bus.mem_we) begin
      ram[bus.mem_wa3[8:0]] <= bus.mem_wd3[7:0];
      wlog_a[wn[5:0]]       <= bus.mem_wa3;
      wlog_d[wn[5:0]]       <= bus.mem_wd3;
      wn                    <= wn + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic port, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      bus.p1_req   = 1'b1;
      bus.p1_we    = we;
      bus.p1_size  = size;
      bus.p1_addr  = addr;
      bus.p1_wdata = wdata;
    end else begin
      bus.p0_req  = 1'b1;
      bus.p0_addr = addr;
    end
  endtask

  // Issue one request, check ack latency / exclusivity / single-cycle width.
  task automatic run(input string tag, input logic port, input logic we,
                     input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, input int exp_cyc);
    int cyc;
    cyc = -1;
    drive(port, we, size, addr, wdata);
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if ((port ? bus.p1_ack : bus.p0_ack) === 1'b1) begin
        cyc = c;
        break;
      end
      @(posedge clk);
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(exp_cyc));
    if (cyc > 0) begin
      chk({tag, ".other_ack"}, {31'd0, port ? bus.p0_ack : bus.p1_ack}, 32'd0);
      chk({tag, ".ack_mem_idle"}, {31'd0, bus.mem_we} | bus.mem_wa3 | bus.mem_ra1 | bus.mem_ra2, 32'd0);
    end
    @(posedge clk);
    #1;
    if (port) bus.p1_req = 1'b0;
    else      bus.p0_req = 1'b0;
    @(negedge clk);
    chk({tag, ".ack_width"}, {31'd0, port ? bus.p1_ack : bus.p0_ack}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          base;
    int          got;
    int          rem0;
    int          rem1;
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    int          eo [4];

    reset = 1'b1;
    ram_init = 1'b1;
    bus.p0_req = 1'b0; bus.p0_addr = 32'd0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_size = 2'b00;
    bus.p1_addr = 32'd0; bus.p1_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 ram_init = 1'b0;

    @(negedge clk);
    chk("rst.p0_ack", {31'd0, bus.p0_ack}, 32'd0);
    chk("rst.p1_ack", {31'd0, bus.p1_ack}, 32'd0);
    chk("rst.mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst.mem_ra1", bus.mem_ra1, 32'd0);
    chk("rst.mem_ra2", bus.mem_ra2, 32'd0);
    chk("rst.mem_wa3", bus.mem_wa3, 32'd0);
    chk("rst.mem_wd3", bus.mem_wd3, 32'd0);
    chk("rst.p0_rdata", bus.p0_rdata, 32'd0);
    chk("rst.p1_rdata", bus.p1_rdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    run("p0_word_0", 1'b0, 1'b0, 2'b10, 32'd0, 32'd0, 3);
    chk("p0_word_0.rdata", bus.p0_rdata, 32'h44332211);

    run("p1_half_511", 1'b1, 1'b0, 2'b01, 32'd511, 32'd0, 2);
    chk("p1_half_511.rdata", bus.p1_rdata, 32'h0000115A);
    chk("p1_half_511.p0_held", bus.p0_rdata, 32'h44332211);

    run("p1_byte_3", 1'b1, 1'b0, 2'b00, 32'd3, 32'd0, 2);
    chk("p1_byte_3.rdata", bus.p1_rdata, 32'h00000044);

    base = wn;
    run("st_word_509", 1'b1, 1'b1, 2'b10, 32'd509, 32'hDEADBEEF, 5);
    chk("st_word_509.nwrites", 32'(wn - base), 32'd4);
    ea = '{32'd509, 32'd510, 32'd511, 32'd0};
    ed = '{32'hEF, 32'hBE, 32'hAD, 32'hDE};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("st_word_509.wa%0d", k), wlog_a[base + k], ea[k]);
      chk($sformatf("st_word_509.wd%0d", k), wlog_d[base + k], ed[k]);
    end
    chk("st_word_509.p1_held", bus.p1_rdata, 32'h00000044);

    base = wn;
    run("st_half_100", 1'b1, 1'b1, 2'b01, 32'd100, 32'h0000ABCD, 3);
    chk("st_half_100.nwrites", 32'(wn - base), 32'd2);
    chk("st_half_100.wa1", wlog_a[base + 1], 32'd101);
    chk("st_half_100.wd1", wlog_d[base + 1], 32'h000000AB);

    base = wn;
    run("st_byte_200", 1'b1, 1'b1, 2'b00, 32'd200, 32'h12345677, 2);
    chk("st_byte_200.nwrites", 32'(wn - base), 32'd1);
    chk("st_byte_200.wd0", wlog_d[base], 32'h00000077);

    run("p0_word_509", 1'b0, 1'b0, 2'b10, 32'd509, 32'd0, 3);
    chk("p0_word_509.rdata", bus.p0_rdata, 32'hDEADBEEF);

    // Reset lands in the second WR cycle of a word store
    base = wn;
    drive(1'b1, 1'b1, 2'b10, 32'd300, 32'h12345678);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort.mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("abort.p1_ack", {31'd0, bus.p1_ack}, 32'd0);
    @(posedge clk);
    #1 bus.p1_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort.nwrites", 32'(wn - base), 32'd1);
    chk("abort.wa0", wlog_a[base], 32'd300);
    chk("abort.wd0", wlog_d[base], 32'h00000078);
    chk("abort.ram301", {24'd0, ram[301]}, 32'd0);
    chk("abort.p0_rdata", bus.p0_rdata, 32'd0);
    chk("abort.p1_ack_after", {31'd0, bus.p1_ack}, 32'd0);
    @(posedge clk);
    #1;
    run("after_abort", 1'b1, 1'b0, 2'b00, 32'd300, 32'd0, 2);
    chk("after_abort.rdata", bus.p1_rdata, 32'h00000078);

    // Contention: both ports request two transactions each
`ifdef MEM_PORT_SEQ_RR_EN
    eo = '{0, 1, 0, 1};
`else
    eo = '{1, 1, 0, 0};
`endif
    rem0 = 2;
    rem1 = 2;
    drive(1'b0, 1'b0, 2'b10, 32'd100, 32'd0);
    drive(1'b1, 1'b0, 2'b00, 32'd200, 32'd0);
    for (int k = 0; k < 4; k++) begin
      got = -1;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (bus.p0_ack === 1'b1 || bus.p1_ack === 1'b1) begin
          got = (bus.p1_ack === 1'b1) ? 1 : 0;
          break;
        end
        @(posedge clk);
      end
      chk($sformatf("arb.owner%0d", k), 32'(got), 32'(eo[k]));
      if (got == 1) begin
        chk($sformatf("arb.p0_ack%0d", k), {31'd0, bus.p0_ack}, 32'd0);
        chk($sformatf("arb.p1_rdata%0d", k), bus.p1_rdata, 32'h00000077);
      end else if (got == 0) begin
        chk($sformatf("arb.p1_ack%0d", k), {31'd0, bus.p1_ack}, 32'd0);
        chk($sformatf("arb.p0_rdata%0d", k), bus.p0_rdata, 32'h0000ABCD);
      end
      @(posedge clk);
      #1;
      if (got == 0) begin
        rem0--;
        if (rem0 == 0) bus.p0_req = 1'b0;
      end else if (got == 1) begin
        rem1--;
        if (rem1 == 0) bus.p1_req = 1'b0;
      end else begin
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        break;
      end
    end
    @(negedge clk);
    chk("arb.end_acks", {30'd0, bus.p1_ack, bus.p0_ack}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
